// File: rtl/ldst_pkg.sv
// Shared types for the load/store unit: FSM encoding, post-modify codes, default widths.
package ldst_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } ldst_state_e;

  typedef enum logic [1:0] {
    POST_NONE = 2'b00,
    POST_INC  = 2'b01,
    POST_DEC  = 2'b10
  } post_e;

  // A load whose destination lands in the pointer pair overrides the post-modify.
  function automatic logic ptr_hazard(input logic store, input logic [3:0] rd,
                                      input logic [3:0] pair);
    return !store && (rd[3:1] == pair[3:1]);
  endfunction

endpackage

// File: rtl/ldst_if.sv
// Decode request, memory and register-file signals of the load/store unit.
interface ldst_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [3:0]        req_rd;
  logic [3:0]        req_ptr_sel;
  logic [1:0]        req_post;
  logic [DATA_W-1:0] ptr_lo;
  logic [DATA_W-1:0] ptr_hi;
  logic [DATA_W-1:0] st_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [3:0]        rf_wsel;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [3:0]        rf_ptr_sel;
  logic              rf_inc;
  logic              rf_dec;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_store, req_rd, req_ptr_sel, req_post, ptr_lo, ptr_hi, st_data,
           mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, rf_wsel, rf_wdata, rf_we,
           rf_ptr_sel, rf_inc, rf_dec, done, err
  );

  modport slave (
    input  req_valid, req_store, req_rd, req_ptr_sel, req_post, ptr_lo, ptr_hi, st_data,
           mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, rf_wsel, rf_wdata, rf_we,
           rf_ptr_sel, rf_inc, rf_dec, done, err
  );
endinterface

// File: rtl/ldst_timeout_ctr.sv
// Down-counter flagging TIMEOUT_CYC consecutive enabled cycles since the last clear.
module ldst_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CTR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CTR_W-1:0] LOAD = CTR_W'(TIMEOUT_CYC - 1);

  logic [CTR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else if (clear) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal count is reached on the TIMEOUT_CYC-th enabled cycle itself.
  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/ldst_unit.sv
// Load/store unit: one req/ack memory access per request, then writeback and pointer post-modify.
// Optional access timeout enabled by defining LDST_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | ready for a request, captures it on valid
// ST_ACCESS | mem_req held until mem_ack (or timeout)
// ST_WB     | one cycle: rf write / inc / dec strobes, done (err on timeout)
module ldst_unit
  import ldst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef LDST_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic   clk,
  input logic   rst_n,
  ldst_if.slave bus
);
  ldst_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        rd_q, pair_q;
  logic [1:0]        post_q;
  logic              store_q;
  logic              accept, ack_acc, tmo_fire, tmo_q, hazard;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign ack_acc = (state_q == ST_ACCESS) && bus.mem_ack;
  assign hazard  = ptr_hazard(store_q, rd_q, pair_q);

`ifdef LDST_TIMEOUT_EN
  logic expired;

  ldst_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state_q == ST_ACCESS),
    .expired (expired)
  );

  // An ack arriving on the expiry cycle still completes the access normally.
  assign tmo_fire = expired && !bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else if (accept) begin
      tmo_q <= 1'b0;
    end else if (tmo_fire) begin
      tmo_q <= 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign tmo_q    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      pair_q  <= '0;
      post_q  <= POST_NONE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {bus.ptr_hi, bus.ptr_lo};
        wdata_q <= bus.st_data;
        rd_q    <= bus.req_rd;
        pair_q  <= bus.req_ptr_sel & 4'hE;
        post_q  <= bus.req_post;
        store_q <= bus.req_store;
      end
      if (ack_acc) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.rf_we      = 1'b0;
    bus.rf_wsel    = '0;
    bus.rf_wdata   = '0;
    bus.rf_ptr_sel = '0;
    bus.rf_inc     = 1'b0;
    bus.rf_dec     = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = store_q;
        if (bus.mem_ack || tmo_fire) state_d = ST_WB;
      end
      ST_WB: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
        if (tmo_q) begin
          bus.err = 1'b1;
        end else begin
          bus.rf_we      = !store_q;
          bus.rf_wsel    = rd_q;
          bus.rf_wdata   = rdata_q;
          bus.rf_ptr_sel = pair_q;
          bus.rf_inc     = (post_q == POST_INC) && !hazard;
          bus.rf_dec     = (post_q == POST_DEC) && !hazard;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Self-checking bench for ldst_unit: vector table plus hand sequences, writeback scoreboard.
module tb_ldst_unit;
  import ldst_pkg::*;

  typedef struct {
    logic        store;
    logic [3:0]  rd;
    logic [3:0]  ptr_sel;
    logic [1:0]  post;
    logic [15:0] ptr;
    logic [7:0]  st_data;
    logic [7:0]  rdata;
    int          k;
    logic        x_we;
    logic [3:0]  x_psel;
    logic        x_inc;
    logic        x_dec;
  } rec_t;

  typedef struct {
    logic       we;
    logic [3:0] wsel;
    logic [7:0] wdata;
    logic [3:0] psel;
    logic       inc;
    logic       dec;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldst_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  ldst_unit #(
    .ADDR_W(16),
    .DATA_W(8)
`ifdef LDST_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  rec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t exp_of(input rec_t r);
    exp_t e;
    e.we    = r.x_we;
    e.wsel  = r.rd;
    e.wdata = r.rdata;
    e.psel  = r.x_psel;
    e.inc   = r.x_inc;
    e.dec   = r.x_dec;
    e.err   = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_rf_we", 32'(bus.rf_we), 32'(e.we));
          check("wb_rf_wsel", 32'(bus.rf_wsel), 32'(e.wsel));
          check("wb_rf_wdata", 32'(bus.rf_wdata), 32'(e.wdata));
          check("wb_rf_ptr_sel", 32'(bus.rf_ptr_sel), 32'(e.psel));
          check("wb_rf_inc", 32'(bus.rf_inc), 32'(e.inc));
          check("wb_rf_dec", 32'(bus.rf_dec), 32'(e.dec));
          check("wb_err", 32'(bus.err), 32'(e.err));
        end
      end else begin
        check("strobes_outside_wb", 32'({bus.rf_we, bus.rf_inc, bus.rf_dec, bus.err}), 32'd0);
      end
    end
  end

  task automatic drive_req(input rec_t r);
    bus.req_store   = r.store;
    bus.req_rd      = r.rd;
    bus.req_ptr_sel = r.ptr_sel;
    bus.req_post    = r.post;
    bus.ptr_hi      = r.ptr[15:8];
    bus.ptr_lo      = r.ptr[7:0];
    bus.st_data     = r.st_data;
  endtask

  task automatic scramble_req();
    bus.req_store   = ~bus.req_store;
    bus.req_rd      = ~bus.req_rd;
    bus.req_ptr_sel = ~bus.req_ptr_sel;
    bus.ptr_hi      = ~bus.ptr_hi;
    bus.ptr_lo      = ~bus.ptr_lo;
    bus.st_data     = ~bus.st_data;
  endtask

  task automatic do_op(input rec_t r);
    @(negedge clk);
    drive_req(r);
    bus.req_valid = 1'b1;
    check("ready_in_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_req();
    sb.push_back(exp_of(r));
    for (int c = 0; c <= r.k; c++) begin
      @(negedge clk);
      check("mem_req_access", 32'(bus.mem_req), 32'd1);
      check("ready_busy", 32'(bus.req_ready), 32'd0);
      if (c == 0) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(r.ptr));
        check("mem_we", 32'(bus.mem_we), 32'(r.store));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(r.st_data));
      end
      if (c == r.k) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = r.rdata;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    check("done_latency", 32'(bus.done), 32'd1);
    check("mem_req_wb", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
  endtask

  rec_t r;
  exp_t e;
  int   n;

  initial begin
    // store rd ptr_sel post ptr st_data rdata k | we psel inc dec
    vecs.push_back('{1'b0, 4'd4, 4'd2, 2'b00, 16'h1234, 8'h00, 8'h5A, 0, 1'b1, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd0, 4'd6, 2'b01, 16'hBEEF, 8'hA5, 8'h11, 3, 1'b0, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd3, 4'd2, 2'b10, 16'h0042, 8'h00, 8'hC3, 1, 1'b1, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd8, 4'd5, 2'b01, 16'hFFFF, 8'h00, 8'h77, 0, 1'b1, 4'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd1, 4'd0, 2'b10, 16'h8000, 8'h5C, 8'h22, 2, 1'b0, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd5, 4'd4, 2'b01, 16'h00FF, 8'h00, 8'h9D, 1, 1'b1, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd9, 4'd3, 2'b11, 16'h7F80, 8'h00, 8'h01, 0, 1'b1, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd7, 4'd0, 2'b10, 16'h0001, 8'h00, 8'hF0, 2, 1'b1, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd6, 4'd7, 2'b00, 16'hA55A, 8'h3E, 8'h44, 3, 1'b0, 4'd6, 1'b0, 1'b0});

    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_rd = '0;
    bus.req_ptr_sel = '0;
    bus.req_post = '0;
    bus.ptr_lo = '0;
    bus.ptr_hi = '0;
    bus.st_data = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    #12;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_rf_bus", 32'({bus.rf_wsel, bus.rf_wdata, bus.rf_ptr_sel}), 32'd0);
    check("rst_strobes", 32'({bus.rf_we, bus.rf_inc, bus.rf_dec, bus.done, bus.err}), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Request held through an op: second accepted only after the first completes.
    @(negedge clk);
    r = '{1'b0, 4'd10, 4'd8, 2'b01, 16'h2468, 8'h00, 8'hAB, 0, 1'b1, 4'd8, 1'b1, 1'b0};
    drive_req(r);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(exp_of(r));
    r = '{1'b1, 4'd2, 4'd12, 2'b10, 16'h1357, 8'h99, 8'h10, 0, 1'b0, 4'd12, 1'b0, 1'b1};
    drive_req(r);
    @(negedge clk);
    check("held_ready_access", 32'(bus.req_ready), 32'd0);
    check("held_addr_first", 32'(bus.mem_addr), 32'h2468);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hAB;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("held_ready_wb", 32'(bus.req_ready), 32'd0);
    check("held_done_first", 32'(bus.done), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("held_ready_idle", 32'(bus.req_ready), 32'd1);
    check("held_no_req_idle", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sb.push_back(exp_of(r));
    @(negedge clk);
    check("held_second_req", 32'(bus.mem_req), 32'd1);
    check("held_second_addr", 32'(bus.mem_addr), 32'h1357);
    check("held_second_we", 32'(bus.mem_we), 32'd1);
    check("held_second_wdata", 32'(bus.mem_wdata), 32'h99);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h10;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("held_done_second", 32'(bus.done), 32'd1);
    @(posedge clk);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    r = '{1'b0, 4'd1, 4'd4, 2'b01, 16'hCAFE, 8'h00, 8'h00, 0, 1'b1, 4'd4, 1'b1, 1'b0};
    drive_req(r);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_req_before", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_req_drop", 32'(bus.mem_req), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_addr_clr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h66;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_ready", 32'(bus.req_ready), 32'd1);
    check("stray_ack_no_req", 32'(bus.mem_req), 32'd0);
    repeat (3) @(negedge clk);

`ifdef LDST_TIMEOUT_EN
    @(negedge clk);
    r = '{1'b0, 4'd1, 4'd6, 2'b01, 16'h0BAD, 8'h00, 8'h00, 0, 1'b1, 4'd6, 1'b1, 1'b0};
    drive_req(r);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e = '{1'b0, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (bus.mem_req && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 32'(n), 32'd4);
    check("tmo_done", 32'(bus.done), 32'd1);
    check("tmo_err", 32'(bus.err), 32'd1);
    @(posedge clk);
    do_op('{1'b0, 4'd8, 4'd2, 2'b01, 16'h4321, 8'h00, 8'h3D, 3, 1'b1, 4'd2, 1'b1, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
